// File: rtl/stat_rd_resp_pkg.sv
// Shared widths, response record, FSM states and address-compare helper
// for the per-flow statistics read responder.
package definitions_bus;

   localparam int A_WIDTH = 10;
   localparam int D_WIDTH = 32;

   typedef struct packed {
      logic [A_WIDTH-1:0] flow;
      logic [D_WIDTH-1:0] pkt_cnt;
      logic [D_WIDTH-1:0] byte_cnt;
   } StatRdResp;

   function automatic logic addr_hit(input logic               wr_en,
                                     input logic [A_WIDTH-1:0] wr_addr,
                                     input logic [A_WIDTH-1:0] rd_addr);
      return wr_en && (wr_addr == rd_addr);
   endfunction

endpackage

package definitions_mem;

   typedef enum logic [1:0] {
      IDLE_SRD,
      RD_SRD,
      CAP_SRD,
      RESP_SRD
   } states_stat_rd;

endpackage

// File: rtl/stat_rd_resp_fwd.sv
// Forwarding for the read-first statistics RAM: a live write in the capture
// cycle beats a write remembered from the read cycle, which beats RAM data.
module stat_rd_fwd
   import definitions_bus::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               rd_cycle_i,
   input  logic               cap_cycle_i,
   input  logic [A_WIDTH-1:0] flow_i,
   input  logic               mem_wr_en_i,
   input  logic [A_WIDTH-1:0] mem_wr_addr_i,
   input  logic [D_WIDTH-1:0] mem_pkt_wdata_i,
   input  logic [D_WIDTH-1:0] mem_byte_wdata_i,
   input  logic [D_WIDTH-1:0] mem_pkt_rdata_i,
   input  logic [D_WIDTH-1:0] mem_byte_rdata_i,
   output logic [D_WIDTH-1:0] fwd_pkt_o,
   output logic [D_WIDTH-1:0] fwd_byte_o
);

   logic               wr_hit;
   logic               pend_vld_q,  pend_vld_d;
   logic [D_WIDTH-1:0] pend_pkt_q,  pend_pkt_d;
   logic [D_WIDTH-1:0] pend_byte_q, pend_byte_d;

   assign wr_hit = addr_hit(mem_wr_en_i, mem_wr_addr_i, flow_i);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         pend_vld_q  <= 1'b0;
         pend_pkt_q  <= '0;
         pend_byte_q <= '0;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_pkt_q  <= pend_pkt_d;
         pend_byte_q <= pend_byte_d;
      end
   end

   // NOTE: each always_comb output gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      pend_vld_d  = pend_vld_q;
      pend_pkt_d  = pend_pkt_q;
      pend_byte_d = pend_byte_q;
      // Every request passes through exactly one read cycle, which rewrites
      // the pending slot, so a stale value never leaks into the next request.
      if (rd_cycle_i) begin
         pend_vld_d = wr_hit;
         if (wr_hit) begin
            pend_pkt_d  = mem_pkt_wdata_i;
            pend_byte_d = mem_byte_wdata_i;
         end
      end
   end

   always_comb begin
      fwd_pkt_o  = mem_pkt_rdata_i;
      fwd_byte_o = mem_byte_rdata_i;
      if (cap_cycle_i && wr_hit) begin
         fwd_pkt_o  = mem_pkt_wdata_i;
         fwd_byte_o = mem_byte_wdata_i;
      end else if (pend_vld_q) begin
         fwd_pkt_o  = pend_pkt_q;
         fwd_byte_o = pend_byte_q;
      end
   end

endmodule

// File: rtl/stat_rd_resp.sv
// Host read responder for the per-flow statistics RAM: one outstanding
// request, single RAM read, write-forwarded snapshot returned via valid/ready.
module stat_rd_resp
   import definitions_bus::*;
   import definitions_mem::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               rd_req_i,
   input  logic [A_WIDTH-1:0] rd_flow_num_i,
   output logic               rd_req_ready_o,
   output logic               rd_valid_o,
   input  logic               rd_ready_i,
   output logic [A_WIDTH-1:0] rd_flow_num_o,
   output logic [D_WIDTH-1:0] rd_pkt_cnt_o,
   output logic [D_WIDTH-1:0] rd_byte_cnt_o,
   output logic               mem_rd_en_o,
   output logic [A_WIDTH-1:0] mem_rd_addr_o,
   input  logic [D_WIDTH-1:0] mem_pkt_rdata_i,
   input  logic [D_WIDTH-1:0] mem_byte_rdata_i,
   input  logic               mem_wr_en_i,
   input  logic [A_WIDTH-1:0] mem_wr_addr_i,
   input  logic [D_WIDTH-1:0] mem_pkt_wdata_i,
   input  logic [D_WIDTH-1:0] mem_byte_wdata_i
);

   states_stat_rd      state_q, state_d;
   logic [A_WIDTH-1:0] flow_q, flow_d;
   logic               mem_rd_en_q, mem_rd_en_d;
   StatRdResp          resp_q, resp_d;
   logic [D_WIDTH-1:0] fwd_pkt, fwd_byte;

   stat_rd_fwd u_fwd (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .rd_cycle_i       (state_q == RD_SRD),
      .cap_cycle_i      (state_q == CAP_SRD),
      .flow_i           (flow_q),
      .mem_wr_en_i      (mem_wr_en_i),
      .mem_wr_addr_i    (mem_wr_addr_i),
      .mem_pkt_wdata_i  (mem_pkt_wdata_i),
      .mem_byte_wdata_i (mem_byte_wdata_i),
      .mem_pkt_rdata_i  (mem_pkt_rdata_i),
      .mem_byte_rdata_i (mem_byte_rdata_i),
      .fwd_pkt_o        (fwd_pkt),
      .fwd_byte_o       (fwd_byte)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE_SRD;
         flow_q      <= '0;
         mem_rd_en_q <= 1'b0;
         resp_q      <= '0;
      end else begin
         state_q     <= state_d;
         flow_q      <= flow_d;
         mem_rd_en_q <= mem_rd_en_d;
         resp_q      <= resp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flow_d      = flow_q;
      mem_rd_en_d = 1'b0;
      resp_d      = resp_q;
      case (state_q)
         IDLE_SRD: begin
            // Read strobe is registered on the accept edge so it is high
            // for exactly the RD_SRD cycle.
            if (rd_req_i) begin
               flow_d      = rd_flow_num_i;
               mem_rd_en_d = 1'b1;
               state_d     = RD_SRD;
            end
         end
         RD_SRD: state_d = CAP_SRD;
         CAP_SRD: begin
            resp_d.flow     = flow_q;
            resp_d.pkt_cnt  = fwd_pkt;
            resp_d.byte_cnt = fwd_byte;
            state_d         = RESP_SRD;
         end
         RESP_SRD: begin
            if (rd_ready_i) state_d = IDLE_SRD;
         end
         default: state_d = IDLE_SRD;
      endcase
   end

   // Ready is gated by reset so the host sees 0 for the whole reset window.
   assign rd_req_ready_o = (state_q == IDLE_SRD) && rst_n_i;
   assign rd_valid_o     = (state_q == RESP_SRD);
   assign rd_flow_num_o  = resp_q.flow;
   assign rd_pkt_cnt_o   = resp_q.pkt_cnt;
   assign rd_byte_cnt_o  = resp_q.byte_cnt;
   assign mem_rd_en_o    = mem_rd_en_q;
   assign mem_rd_addr_o  = flow_q;

endmodule

// File: tb/tb_stat_rd_resp.sv
// Directed bench for stat_rd_resp: table of single-read forwarding vectors
// plus backpressure, mid-transaction reset and back-to-back sequences.
module tb_stat_rd_resp;

   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] pkt;
      logic [DW-1:0] byt;
   } wr_t;

   typedef struct packed {
      logic [AW-1:0] flow;
      logic [DW-1:0] pre_pkt;
      logic [DW-1:0] pre_byte;
      wr_t           w_rd;
      wr_t           w_cap;
      wr_t           w_resp;
      logic [DW-1:0] exp_pkt;
      logic [DW-1:0] exp_byte;
   } vec_t;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          rd_req_i = 1'b0;
   logic [AW-1:0] rd_flow_num_i = '0;
   logic          rd_req_ready_o;
   logic          rd_valid_o;
   logic          rd_ready_i = 1'b0;
   logic [AW-1:0] rd_flow_num_o;
   logic [DW-1:0] rd_pkt_cnt_o;
   logic [DW-1:0] rd_byte_cnt_o;
   logic          mem_rd_en_o;
   logic [AW-1:0] mem_rd_addr_o;
   logic [DW-1:0] mem_pkt_rdata_i = '0;
   logic [DW-1:0] mem_byte_rdata_i = '0;
   logic          mem_wr_en_i = 1'b0;
   logic [AW-1:0] mem_wr_addr_i = '0;
   logic [DW-1:0] mem_pkt_wdata_i = '0;
   logic [DW-1:0] mem_byte_wdata_i = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] pkt_mem  [1024];
   logic [DW-1:0] byte_mem [1024];

   always #5 clk_i = ~clk_i;

   stat_rd_resp dut (
      .clk_i            (clk_i),
      .rst_n_i          (rst_n_i),
      .rd_req_i         (rd_req_i),
      .rd_flow_num_i    (rd_flow_num_i),
      .rd_req_ready_o   (rd_req_ready_o),
      .rd_valid_o       (rd_valid_o),
      .rd_ready_i       (rd_ready_i),
      .rd_flow_num_o    (rd_flow_num_o),
      .rd_pkt_cnt_o     (rd_pkt_cnt_o),
      .rd_byte_cnt_o    (rd_byte_cnt_o),
      .mem_rd_en_o      (mem_rd_en_o),
      .mem_rd_addr_o    (mem_rd_addr_o),
      .mem_pkt_rdata_i  (mem_pkt_rdata_i),
      .mem_byte_rdata_i (mem_byte_rdata_i),
      .mem_wr_en_i      (mem_wr_en_i),
      .mem_wr_addr_i    (mem_wr_addr_i),
      .mem_pkt_wdata_i  (mem_pkt_wdata_i),
      .mem_byte_wdata_i (mem_byte_wdata_i)
   );

   // Read-first dual-port RAM with one-cycle read latency.
   always @(posedge clk_i) begin
      if (mem_rd_en_o) begin
         mem_pkt_rdata_i  <= pkt_mem[mem_rd_addr_o];
         mem_byte_rdata_i <= byte_mem[mem_rd_addr_o];
      end
      if (mem_wr_en_i) begin
         pkt_mem[mem_wr_addr_i]  <= mem_pkt_wdata_i;
         byte_mem[mem_wr_addr_i] <= mem_byte_wdata_i;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
   endtask

   function automatic wr_t mk_wr(input logic en, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] pkt, input logic [DW-1:0] byt);
      wr_t w;
      w.en   = en;
      w.addr = addr;
      w.pkt  = pkt;
      w.byt  = byt;
      return w;
   endfunction

   function automatic vec_t mk_vec(input logic [AW-1:0] flow,
                                   input logic [DW-1:0] pre_pkt, input logic [DW-1:0] pre_byte,
                                   input wr_t w_rd, input wr_t w_cap, input wr_t w_resp,
                                   input logic [DW-1:0] exp_pkt, input logic [DW-1:0] exp_byte);
      vec_t v;
      v.flow     = flow;
      v.pre_pkt  = pre_pkt;
      v.pre_byte = pre_byte;
      v.w_rd     = w_rd;
      v.w_cap    = w_cap;
      v.w_resp   = w_resp;
      v.exp_pkt  = exp_pkt;
      v.exp_byte = exp_byte;
      return v;
   endfunction

   task automatic drive_wr(input wr_t w);
      mem_wr_en_i      = w.en;
      mem_wr_addr_i    = w.addr;
      mem_pkt_wdata_i  = w.pkt;
      mem_byte_wdata_i = w.byt;
   endtask

   task automatic preload(input logic [AW-1:0] flow, input logic [DW-1:0] pkt, input logic [DW-1:0] byt);
      drive_wr(mk_wr(1'b1, flow, pkt, byt));
      step();
      drive_wr('0);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
   task automatic run_vec(input string tag, input vec_t v);
      preload(v.flow, v.pre_pkt, v.pre_byte);
      check({tag, " ready idle"}, 32'(rd_req_ready_o), 32'd1);
      rd_req_i      = 1'b1;
      rd_flow_num_i = v.flow;
      rd_ready_i    = 1'b1;
      step();
      rd_req_i = 1'b0;
      check({tag, " rd_en in RD"}, 32'(mem_rd_en_o), 32'd1);
      check({tag, " rd_addr"}, 32'(mem_rd_addr_o), 32'(v.flow));
      check({tag, " valid in RD"}, 32'(rd_valid_o), 32'd0);
      drive_wr(v.w_rd);
      step();
      check({tag, " rd_en in CAP"}, 32'(mem_rd_en_o), 32'd0);
      check({tag, " valid in CAP"}, 32'(rd_valid_o), 32'd0);
      check({tag, " ready busy"}, 32'(rd_req_ready_o), 32'd0);
      drive_wr(v.w_cap);
      step();
      check({tag, " valid"}, 32'(rd_valid_o), 32'd1);
      check({tag, " flow"}, 32'(rd_flow_num_o), 32'(v.flow));
      check({tag, " pkt"}, rd_pkt_cnt_o, v.exp_pkt);
      check({tag, " byte"}, rd_byte_cnt_o, v.exp_byte);
      drive_wr(v.w_resp);
      step();
      drive_wr('0);
      check({tag, " valid after hs"}, 32'(rd_valid_o), 32'd0);
      check({tag, " ready after hs"}, 32'(rd_req_ready_o), 32'd1);
   endtask

   vec_t vecs [9];
   wr_t  no_wr;

   initial begin
      logic [AW-1:0] flows [3];
      int req_idx, rsp_idx, last_cyc, quiet_err;

      no_wr = '0;
      vecs[0] = mk_vec(10'd5, 32'd3, 32'd1500, no_wr, no_wr, no_wr, 32'd3, 32'd1500);
      vecs[1] = mk_vec(10'd5, 32'd3, 32'd1500, mk_wr(1'b1, 10'd5, 32'd4, 32'd1564),
                       no_wr, no_wr, 32'd4, 32'd1564);
      vecs[2] = mk_vec(10'd5, 32'd3, 32'd1500, mk_wr(1'b1, 10'd5, 32'd4, 32'd1564),
                       mk_wr(1'b1, 10'd5, 32'd5, 32'd1628), no_wr, 32'd5, 32'd1628);
      vecs[3] = mk_vec(10'd5, 32'd3, 32'd1500, mk_wr(1'b1, 10'd6, 32'd4, 32'd1564),
                       no_wr, no_wr, 32'd3, 32'd1500);
      vecs[4] = mk_vec(10'd5, 32'd3, 32'd1500, no_wr,
                       mk_wr(1'b1, 10'd5, 32'd7, 32'd2000), no_wr, 32'd7, 32'd2000);
      vecs[5] = mk_vec(10'd5, 32'd3, 32'd1500, mk_wr(1'b1, 10'd5, 32'd9, 32'd99),
                       mk_wr(1'b1, 10'd6, 32'd8, 32'd88), no_wr, 32'd9, 32'd99);
      vecs[6] = mk_vec(10'd1023, 32'hFFFF_FFFF, 32'hDEAD_BEEF, no_wr, no_wr, no_wr,
                       32'hFFFF_FFFF, 32'hDEAD_BEEF);
      vecs[7] = mk_vec(10'd0, 32'd1, 32'd64, mk_wr(1'b1, 10'd5, 32'd2, 32'd128),
                       no_wr, no_wr, 32'd1, 32'd64);
      vecs[8] = mk_vec(10'd5, 32'd3, 32'd1500, no_wr, no_wr,
                       mk_wr(1'b1, 10'd5, 32'd50, 32'd5000), 32'd3, 32'd1500);

      // Reset state.
      step();
      step();
      check("rst ready", 32'(rd_req_ready_o), 32'd0);
      check("rst valid", 32'(rd_valid_o), 32'd0);
      check("rst rd_en", 32'(mem_rd_en_o), 32'd0);
      check("rst rd_addr", 32'(mem_rd_addr_o), 32'd0);
      check("rst flow", 32'(rd_flow_num_o), 32'd0);
      check("rst pkt", rd_pkt_cnt_o, 32'd0);
      check("rst byte", rd_byte_cnt_o, 32'd0);
      rst_n_i = 1'b1;
      step();
      check("post-rst ready", 32'(rd_req_ready_o), 32'd1);

      for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: response must hold and a new request must be ignored.
      preload(10'd7, 32'd70, 32'd7000);
      rd_req_i      = 1'b1;
      rd_flow_num_i = 10'd7;
      rd_ready_i    = 1'b0;
      step();
      rd_req_i = 1'b0;
      step();
      step();
      check("bp valid", 32'(rd_valid_o), 32'd1);
      for (int i = 0; i < 10; i++) begin
         rd_req_i      = (i == 2 || i == 3);
         rd_flow_num_i = 10'd9;
         step();
         check($sformatf("bp hold valid c%0d", i), 32'(rd_valid_o), 32'd1);
         check($sformatf("bp hold flow c%0d", i), 32'(rd_flow_num_o), 32'd7);
         check($sformatf("bp hold pkt c%0d", i), rd_pkt_cnt_o, 32'd70);
         check($sformatf("bp hold byte c%0d", i), rd_byte_cnt_o, 32'd7000);
         check($sformatf("bp ready low c%0d", i), 32'(rd_req_ready_o), 32'd0);
         check($sformatf("bp no read c%0d", i), 32'(mem_rd_en_o), 32'd0);
      end
      rd_req_i   = 1'b0;
      rd_ready_i = 1'b1;
      step();
      check("bp released valid", 32'(rd_valid_o), 32'd0);
      check("bp flow9 not taken", 32'(mem_rd_en_o), 32'd0);
      run_vec("bp flow9", mk_vec(10'd9, 32'd90, 32'd9000, no_wr, no_wr, no_wr, 32'd90, 32'd9000));

      // Reset asserted during the capture cycle.
      preload(10'd5, 32'd3, 32'd1500);
      rd_req_i      = 1'b1;
      rd_flow_num_i = 10'd5;
      step();
      rd_req_i = 1'b0;
      step();
      rst_n_i = 1'b0;
      step();
      check("midrst valid", 32'(rd_valid_o), 32'd0);
      check("midrst flow", 32'(rd_flow_num_o), 32'd0);
      check("midrst pkt", rd_pkt_cnt_o, 32'd0);
      check("midrst byte", rd_byte_cnt_o, 32'd0);
      check("midrst rd_en", 32'(mem_rd_en_o), 32'd0);
      check("midrst rd_addr", 32'(mem_rd_addr_o), 32'd0);
      check("midrst ready", 32'(rd_req_ready_o), 32'd0);
      rst_n_i = 1'b1;
      quiet_err = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rd_valid_o !== 1'b0 || rd_req_ready_o !== 1'b1) quiet_err++;
      end
      check("midrst no response", 32'(quiet_err), 32'd0);
      run_vec("after rst 1023", mk_vec(10'd1023, 32'd12, 32'd3456, no_wr, no_wr, no_wr,
                                       32'd12, 32'd3456));

      // Back-to-back: host holds rd_req_i high, advancing the flow on accept.
      flows[0] = 10'd1;
      flows[1] = 10'd2;
      flows[2] = 10'd3;
      for (int i = 0; i < 3; i++) preload(flows[i], 32'(11 * (i + 1)), 32'(110 * (i + 1)));
      rd_ready_i = 1'b1;
      req_idx  = 0;
      rsp_idx  = 0;
      last_cyc = -1;
      for (int cyc = 0; cyc < 40 && rsp_idx < 3; cyc++) begin
         if (rd_valid_o) begin
            check($sformatf("b2b flow r%0d", rsp_idx), 32'(rd_flow_num_o), 32'(flows[rsp_idx]));
            check($sformatf("b2b pkt r%0d", rsp_idx), rd_pkt_cnt_o, 32'(11 * (rsp_idx + 1)));
            check($sformatf("b2b byte r%0d", rsp_idx), rd_byte_cnt_o, 32'(110 * (rsp_idx + 1)));
            if (rsp_idx > 0) check($sformatf("b2b gap r%0d", rsp_idx), 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            rsp_idx++;
         end
         if (rd_req_ready_o) begin
            if (req_idx < 3) begin
               rd_req_i      = 1'b1;
               rd_flow_num_i = flows[req_idx];
               req_idx++;
            end else begin
               rd_req_i = 1'b0;
            end
         end
         step();
      end
      rd_req_i = 1'b0;
      check("b2b response count", 32'(rsp_idx), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
